// File: rtl/pll_drp_pkg.sv
// Shared types and helpers for the PLL DRP reconfiguration sequencer.
package pll_drp_pkg;

  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;

  typedef enum logic [3:0] {
    IDLE,
    HOLD_RST,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    NEXT,
    WAIT_LOCK,
    FIN_OK,
    FIN_ERR
  } state_t;

  // Read-modify-write merge: mask bits set keep the value read back,
  // mask bits clear take the table data.
  function automatic logic [DRP_DATA_W-1:0] drp_merge(
    input logic [DRP_DATA_W-1:0] rd,
    input logic [DRP_DATA_W-1:0] mask,
    input logic [DRP_DATA_W-1:0] data
  );
    return (rd & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the PLL LOCKED flag into the DCLK domain.
module pll_lock_sync (
  input  logic clk,
  input  logic rstn,
  input  logic locked,
  output logic locked_sync
);

  logic lock_p0;
  logic lock_p1;

  // Stage 0 captures the asynchronous flag, stage 1 settles metastability.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      lock_p0 <= locked;
      lock_p1 <= lock_p0;
    end
  end

  assign locked_sync = lock_p1;

endmodule

// File: rtl/pll_drp_reconfig.sv
// DRP reconfiguration sequencer: holds the PLL in reset, walks an external
// (address, mask, data) table doing read-modify-writes, then waits for lock.
module pll_drp_reconfig
  import pll_drp_pkg::*;
#(
  parameter int  NUM_ENTRIES  = 23,
  parameter int  DRDY_TIMEOUT = 64,
  parameter int  LOCK_TIMEOUT = 4096,
  parameter int  RST_HOLD     = 4,
  localparam int IDX_W        = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                  DCLK,
  input  logic                  RSTN,
  input  logic                  START,
  output logic [IDX_W-1:0]      ENTRY_IDX,
  input  logic [DRP_ADDR_W-1:0] ENTRY_ADDR,
  input  logic [DRP_DATA_W-1:0] ENTRY_MASK,
  input  logic [DRP_DATA_W-1:0] ENTRY_DATA,
  output logic [DRP_ADDR_W-1:0] DADDR,
  output logic [DRP_DATA_W-1:0] DI,
  output logic                  DEN,
  output logic                  DWE,
  input  logic [DRP_DATA_W-1:0] DO,
  input  logic                  DRDY,
  input  logic                  LOCKED,
  output logic                  PLL_RST,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int CNT_MAX_DL = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CNT_MAX    = (CNT_MAX_DL > RST_HOLD) ? CNT_MAX_DL : RST_HOLD;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RST_HOLD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_ENTRIES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_done;
  logic             locked_sync;

  pll_lock_sync u_lock_sync (
    .clk         (DCLK),
    .rstn        (RSTN),
    .locked      (LOCKED),
    .locked_sync (locked_sync)
  );

  // Sequencer FSM. DEN/DADDR are registered on entry to RD_REQ/WR_REQ so the
  // strobe is high exactly during that state. The table index advances at the
  // end of WR_WAIT so the combinational lookup already shows the next entry
  // while NEXT launches its read; last_done remembers the final entry.
  always_ff @(posedge DCLK) begin
    if (!RSTN) begin
      state     <= IDLE;
      cnt       <= '0;
      last_done <= 1'b0;
      ENTRY_IDX <= '0;
      DADDR     <= '0;
      DI        <= '0;
      DEN       <= 1'b0;
      DWE       <= 1'b0;
      PLL_RST   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN_OK, FIN_ERR: begin
          if (START) begin
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            BUSY      <= 1'b1;
            PLL_RST   <= 1'b1;
            ENTRY_IDX <= '0;
            last_done <= 1'b0;
            cnt       <= HOLD_LOAD;
            state     <= HOLD_RST;
          end
        end
        HOLD_RST: begin
          if (cnt == '0) begin
            DADDR <= ENTRY_ADDR;
            DEN   <= 1'b1;
            DWE   <= 1'b0;
            state <= RD_REQ;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RD_REQ: begin
          DEN   <= 1'b0;
          cnt   <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (DRDY) begin
            DI    <= drp_merge(DO, ENTRY_MASK, ENTRY_DATA);
            DEN   <= 1'b1;
            DWE   <= 1'b1;
            state <= WR_REQ;
          end else if (cnt == DRDY_LAST) begin
            PLL_RST <= 1'b0;
            BUSY    <= 1'b0;
            ERR     <= 1'b1;
            state   <= FIN_ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WR_REQ: begin
          DEN   <= 1'b0;
          DWE   <= 1'b0;
          cnt   <= '0;
          state <= WR_WAIT;
        end
        WR_WAIT: begin
          if (DRDY) begin
            if (ENTRY_IDX == IDX_LAST) begin
              last_done <= 1'b1;
            end else begin
              ENTRY_IDX <= ENTRY_IDX + IDX_W'(1);
            end
            state <= NEXT;
          end else if (cnt == DRDY_LAST) begin
            PLL_RST <= 1'b0;
            BUSY    <= 1'b0;
            ERR     <= 1'b1;
            state   <= FIN_ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        NEXT: begin
          if (last_done) begin
            PLL_RST <= 1'b0;
            cnt     <= '0;
            state   <= WAIT_LOCK;
          end else begin
            DADDR <= ENTRY_ADDR;
            DEN   <= 1'b1;
            DWE   <= 1'b0;
            state <= RD_REQ;
          end
        end
        WAIT_LOCK: begin
          if (locked_sync) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= FIN_OK;
          end else if (cnt == LOCK_LAST) begin
            BUSY  <= 1'b0;
            ERR   <= 1'b1;
            state <= FIN_ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Bench for pll_drp_reconfig: a 23-entry instance with a randomized table and
// a behavioural DRP/lock model, plus a single-entry instance.
module tb_pll_drp_reconfig;

  logic DCLK = 1'b0;
  logic RSTN = 1'b0;
  always #5 DCLK = ~DCLK;

  // 23-entry instance
  logic        start_m;
  logic [4:0]  idx_m;
  logic [6:0]  addr_m, daddr_m;
  logic [15:0] mask_m, data_m, di_m;
  logic [15:0] do_m = 16'h0;
  logic        den_m, dwe_m, pll_rst_m, busy_m, done_m, err_m;
  logic        drdy_m = 1'b0;
  logic        drdy_force;
  logic        drdy_w;
  logic        lock_m = 1'b0;

  // single-entry instance
  logic        start_o;
  logic [0:0]  idx_o;
  logic [6:0]  addr_o = 7'h08;
  logic [15:0] mask_o = 16'h1000;
  logic [15:0] data_o = 16'h0041;
  logic [15:0] do_o   = 16'hFFFF;
  logic [6:0]  daddr_o;
  logic [15:0] di_o;
  logic        den_o, dwe_o, pll_rst_o, busy_o, done_o, err_o;
  logic        drdy_o = 1'b0;
  logic        lock_o = 1'b1;

  logic [6:0]  tab_addr[32];
  logic [15:0] tab_mask[32];
  logic [15:0] tab_data[32];
  logic [15:0] rd_val[128];
  logic        withhold;
  logic        lock_en;
  int          lock_dly;
  int          lock_cnt = 0;

  assign addr_m = tab_addr[idx_m];
  assign mask_m = tab_mask[idx_m];
  assign data_m = tab_data[idx_m];
  assign drdy_w = drdy_m | drdy_force;

  pll_drp_reconfig #(
    .NUM_ENTRIES(23), .DRDY_TIMEOUT(64), .LOCK_TIMEOUT(100), .RST_HOLD(4)
  ) u_dut (
    .DCLK(DCLK), .RSTN(RSTN), .START(start_m), .ENTRY_IDX(idx_m),
    .ENTRY_ADDR(addr_m), .ENTRY_MASK(mask_m), .ENTRY_DATA(data_m),
    .DADDR(daddr_m), .DI(di_m), .DEN(den_m), .DWE(dwe_m), .DO(do_m),
    .DRDY(drdy_w), .LOCKED(lock_m), .PLL_RST(pll_rst_m), .BUSY(busy_m),
    .DONE(done_m), .ERR(err_m)
  );

  pll_drp_reconfig #(
    .NUM_ENTRIES(1), .DRDY_TIMEOUT(64), .LOCK_TIMEOUT(100), .RST_HOLD(4)
  ) u_one (
    .DCLK(DCLK), .RSTN(RSTN), .START(start_o), .ENTRY_IDX(idx_o),
    .ENTRY_ADDR(addr_o), .ENTRY_MASK(mask_o), .ENTRY_DATA(data_o),
    .DADDR(daddr_o), .DI(di_o), .DEN(den_o), .DWE(dwe_o), .DO(do_o),
    .DRDY(drdy_o), .LOCKED(lock_o), .PLL_RST(pll_rst_o), .BUSY(busy_o),
    .DONE(done_o), .ERR(err_o)
  );

  // DRP register model: answers one cycle after each strobe, except a
  // suppressed read of entry 3 when withhold is set.
  always @(posedge DCLK) begin
    drdy_m <= 1'b0;
    if (RSTN && den_m && (dwe_m || !(withhold && idx_m == 5'd3))) begin
      drdy_m <= 1'b1;
      if (!dwe_m) do_m <= rd_val[daddr_m];
    end
  end

  always @(posedge DCLK) drdy_o <= RSTN && den_o;

  // PLL lock model: locks lock_dly cycles after reset release when enabled.
  always @(posedge DCLK) begin
    if (pll_rst_m || !lock_en) begin
      lock_m   <= 1'b0;
      lock_cnt <= 0;
    end else if (lock_cnt >= lock_dly) begin
      lock_m <= 1'b1;
    end else begin
      lock_cnt <= lock_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          den_cnt, first_den_cyc, rd3_cyc, rst_fall_cyc, err_cyc, idx_bad, idx_max;
  logic        prev_rst, prev_err, done_seen;
  logic [4:0]  prev_idx;
  logic [6:0]  wa_q[$];
  logic [15:0] wd_q[$];
  int          one_den, one_first_den, one_wr_cyc, one_rst_fall;
  logic [15:0] one_wr_data;
  logic [6:0]  one_wr_addr;
  logic [3:0]  one_dwe_bits;
  logic        one_prev_rst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_write(input int i);
    logic [15:0] rd;
    rd = rd_val[tab_addr[i]];
    return (rd & tab_mask[i]) | (tab_data[i] & ~tab_mask[i]);
  endfunction

  task automatic clear_stats();
    den_cnt = 0; first_den_cyc = -1; rd3_cyc = -1; rst_fall_cyc = -1;
    err_cyc = -1; idx_bad = 0; idx_max = 0; done_seen = 1'b0;
    prev_rst = pll_rst_m; prev_err = err_m; prev_idx = 5'd0;
    wa_q.delete(); wd_q.delete();
    one_den = 0; one_first_den = -1; one_wr_cyc = -1; one_rst_fall = -1;
    one_wr_data = 16'h0; one_wr_addr = 7'h0; one_dwe_bits = 4'h0;
    one_prev_rst = pll_rst_o;
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge DCLK);
    #1;
    cyc++;
    if (den_m) begin
      den_cnt++;
      if (first_den_cyc < 0) first_den_cyc = cyc;
      if (dwe_m) begin
        wa_q.push_back(daddr_m);
        wd_q.push_back(di_m);
      end else if (idx_m == 5'd3 && rd3_cyc < 0) begin
        rd3_cyc = cyc;
      end
    end
    if (prev_rst && !pll_rst_m) rst_fall_cyc = cyc;
    if (!prev_err && err_m) err_cyc = cyc;
    if (idx_m != prev_idx && idx_m != prev_idx + 5'd1) idx_bad++;
    if (int'(idx_m) > idx_max) idx_max = int'(idx_m);
    if (done_m) done_seen = 1'b1;
    prev_rst = pll_rst_m; prev_err = err_m; prev_idx = idx_m;
    if (den_o) begin
      one_den++;
      one_dwe_bits = {one_dwe_bits[2:0], dwe_o};
      if (one_first_den < 0) one_first_den = cyc;
      if (dwe_o) begin
        one_wr_data = di_o;
        one_wr_addr = daddr_o;
        one_wr_cyc  = cyc;
      end
    end
    if (one_prev_rst && !pll_rst_o) one_rst_fall = cyc;
    one_prev_rst = pll_rst_o;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int d0;
    int base;
    start_m = 1'b0; start_o = 1'b0; drdy_force = 1'b0;
    withhold = 1'b0; lock_en = 1'b1; lock_dly = 5;
    base = int'($urandom_range(0, 127));
    for (int i = 0; i < 32; i++) begin
      tab_addr[i] = 7'((i * 5 + base) % 128);
      tab_mask[i] = 16'($urandom);
      tab_data[i] = 16'($urandom);
    end
    for (int a = 0; a < 128; a++) rd_val[a] = 16'($urandom);

    // Reset state
    RSTN = 1'b0;
    repeat (3) step();
    chk("rst_ctrl", 32'({err_m, done_m, busy_m, pll_rst_m, den_m, dwe_m}), 32'd0);
    chk("rst_idx", 32'(idx_m), 32'd0);
    chk("rst_daddr_di", 32'({daddr_m, di_m}), 32'd0);
    chk("rst_one_ctrl", 32'({err_o, done_o, busy_o, pll_rst_o, den_o, dwe_o}), 32'd0);
    RSTN = 1'b1;
    step();

    // Single entry: 0xFFFF & 0x1000 | 0x0041 & ~0x1000 = 0x1041
    clear_stats();
    start_o = 1'b1; step(); start_o = 1'b0; t0 = cyc;
    chk("one_start_rise", 32'({pll_rst_o, busy_o}), 32'd3);
    for (int k = 0; k < 100 && !done_o && !err_o; k++) step();
    chk("one_done", 32'({done_o, busy_o, err_o, pll_rst_o}), 32'b1000);
    chk("one_den_count", 32'(one_den), 32'd2);
    chk("one_dwe_order", 32'(one_dwe_bits), 32'b0001);
    chk("one_wr_data", 32'(one_wr_data), 32'h1041);
    chk("one_wr_addr", 32'(one_wr_addr), 32'h08);
    chk("one_first_den_lat", 32'(one_first_den - t0), 32'd5);
    chk("one_rst_after_wr", 32'(one_rst_fall > one_wr_cyc && one_wr_cyc > 0), 32'd1);

    // Full table, with an ignored START in the middle
    clear_stats();
    start_m = 1'b1; step(); start_m = 1'b0; t0 = cyc;
    chk("full_start", 32'({pll_rst_m, busy_m, done_m, err_m}), 32'b1100);
    for (int k = 0; k < 600 && !done_m && !err_m; k++) begin
      start_m = (k == 40);
      step();
    end
    start_m = 1'b0;
    chk("full_done", 32'({done_m, busy_m, err_m, pll_rst_m}), 32'b1000);
    chk("full_den_count", 32'(den_cnt), 32'd46);
    chk("full_idx_max", 32'(idx_max), 32'd22);
    chk("full_idx_steps", 32'(idx_bad), 32'd0);
    chk("full_first_den_lat", 32'(first_den_cyc - t0), 32'd5);
    chk("full_wr_count", 32'(wa_q.size()), 32'd23);
    for (int i = 0; i < wa_q.size(); i++) begin
      chk($sformatf("full_wr_addr_%0d", i), 32'(wa_q[i]), 32'(tab_addr[i]));
      chk($sformatf("full_wr_data_%0d", i), 32'(wd_q[i]), 32'(ref_write(i)));
    end

    // DRDY withheld on entry 3 read
    withhold = 1'b1;
    clear_stats();
    start_m = 1'b1; step(); start_m = 1'b0;
    for (int k = 0; k < 1000 && !done_m && !err_m; k++) step();
    chk("drdy_to_flags", 32'({err_m, done_m, busy_m, pll_rst_m}), 32'b1000);
    chk("drdy_to_latency", 32'(err_cyc - rd3_cyc), 32'd65);
    chk("drdy_to_den_count", 32'(den_cnt), 32'd7);
    d0 = den_cnt;
    repeat (80) step();
    chk("drdy_to_no_more_den", 32'(den_cnt - d0), 32'd0);
    chk("drdy_to_err_hold", 32'({err_m, busy_m}), 32'b10);
    withhold = 1'b0;

    // Restart after FIN_ERR, then lock timeout
    lock_en = 1'b0;
    clear_stats();
    start_m = 1'b1; step(); start_m = 1'b0;
    chk("restart_clear_err", 32'({err_m, busy_m, pll_rst_m}), 32'b011);
    chk("restart_idx", 32'(idx_m), 32'd0);
    for (int k = 0; k < 1000 && !done_m && !err_m; k++) step();
    chk("lock_to_flags", 32'({err_m, done_seen, busy_m, pll_rst_m}), 32'b1000);
    chk("lock_to_latency", 32'(err_cyc - rst_fall_cyc), 32'd100);
    chk("lock_to_wr_count", 32'(wa_q.size()), 32'd23);
    lock_en = 1'b1;

    // Reset asserted during WR_WAIT, stale DRDY afterwards
    clear_stats();
    start_m = 1'b1; step(); start_m = 1'b0;
    for (int k = 0; k < 200 && !(den_m && dwe_m); k++) step();
    chk("wr_req_seen", 32'(den_m && dwe_m), 32'd1);
    step();
    chk("wr_wait_drdy", 32'(drdy_m), 32'd1);
    RSTN = 1'b0;
    step();
    chk("midrst_ctrl", 32'({err_m, done_m, busy_m, pll_rst_m, den_m, dwe_m}), 32'd0);
    chk("midrst_idx", 32'(idx_m), 32'd0);
    chk("midrst_daddr_di", 32'({daddr_m, di_m}), 32'd0);
    RSTN = 1'b1;
    d0 = den_cnt;
    drdy_force = 1'b1;
    step(); step();
    drdy_force = 1'b0;
    repeat (10) step();
    chk("stale_drdy_ctrl", 32'({err_m, done_m, busy_m, pll_rst_m, den_m, dwe_m}), 32'd0);
    chk("stale_drdy_no_den", 32'(den_cnt - d0), 32'd0);
    chk("stale_drdy_idx", 32'(idx_m), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_drp_reconfig.md
# pll_drp_reconfig

Dynamic-reconfiguration sequencer that sits directly upstream of the PLL model's DRP port. On a start request it holds the PLL in reset and walks a caller-supplied table of (address, mask, data) entries. For each entry it does a DRP read-modify-write, then releases reset and waits for lock, reporting done or error. It lets testbenches and SoC models retune CLKOUTx/CLKFBOUT at run time without re-elaborating the PLL.

## Interface
Parameters:
- NUM_ENTRIES, 23: table length; entry index width is clog2(NUM_ENTRIES), minimum 1.
- DRDY_TIMEOUT, 64: maximum DCLK cycles to wait for DRDY after a DEN pulse.
- LOCK_TIMEOUT, 4096: maximum DCLK cycles to wait for synchronized LOCKED after PLL reset release.
- RST_HOLD, 4: minimum DCLK cycles PLL_RST stays high before the first DRP access.

Ports:
- DCLK  in  1  single clock for the whole block; also drives the PLL DRP.
- RSTN  in  1  reset: synchronous, active-low.
- START  in  1  one-cycle request to begin a reconfiguration.
- ENTRY_IDX  out  clog2(NUM_ENTRIES)  table index currently requested.
- ENTRY_ADDR  in  7  DRP address for ENTRY_IDX; combinational, same cycle.
- ENTRY_MASK  in  16  bits set to 1 preserve the read value.
- ENTRY_DATA  in  16  bits OR-ed in after masking.
- DADDR  out  7  to PLL.
- DI  out  16  to PLL.
- DEN  out  1  to PLL.
- DWE  out  1  to PLL.
- DO  in  16  from PLL.
- DRDY  in  1  from PLL.
- LOCKED  in  1  from PLL; asynchronous to DCLK.
- PLL_RST  out  1  to PLL RST.
- BUSY  out  1  sequence in progress.
- DONE  out  1  last sequence finished with lock.
- ERR  out  1  last sequence aborted on a timeout.

## Operation
- States: IDLE, HOLD_RST, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, WAIT_LOCK, FIN_OK, FIN_ERR.
- IDLE / FIN_OK / FIN_ERR: a START pulse clears DONE and ERR, sets BUSY and PLL_RST, sets ENTRY_IDX=0, loads the hold counter, and goes to HOLD_RST.
- START is ignored in every other state.
- HOLD_RST: count RST_HOLD cycles, then go to RD_REQ.
- RD_REQ: DADDR=ENTRY_ADDR, DEN=1, DWE=0 for exactly one cycle; then RD_WAIT.
- RD_WAIT: when DRDY=1, register DI = (DO & ENTRY_MASK) | (ENTRY_DATA & ~ENTRY_MASK), then go to WR_REQ.
- WR_REQ: DEN=1, DWE=1, DADDR held, for one cycle; then WR_WAIT.
- WR_WAIT: when DRDY=1, go to NEXT.
- NEXT: if ENTRY_IDX==NUM_ENTRIES-1, deassert PLL_RST and go to WAIT_LOCK. Otherwise increment ENTRY_IDX and go to RD_REQ.
- WAIT_LOCK: when synchronized LOCKED=1, go to FIN_OK.
- Timeouts: the DRDY counter runs in RD_WAIT/WR_WAIT and the lock counter in WAIT_LOCK.
- On a timeout: go to FIN_ERR, deassert PLL_RST, and set ERR=1.
- FIN_OK: BUSY=0, DONE=1. FIN_ERR: BUSY=0, ERR=1. Both hold until the next START or reset.
- DRDY seen outside RD_WAIT/WR_WAIT is ignored.
- DEN is never asserted while a prior access is outstanding.

## Timing
- Reset (RSTN=0 at a DCLK edge): state IDLE, DADDR=0, DI=0, DEN=0, DWE=0, PLL_RST=0, BUSY=0, DONE=0, ERR=0, ENTRY_IDX=0, counters 0.
- Reset mid-sequence aborts at once to these values. No DRP access is completed.
- All outputs are registered.
- PLL_RST and BUSY rise on the edge after the START cycle.
- The first DEN occurs RST_HOLD+1 cycles after the edge where PLL_RST rises.
- DRDY in the same cycle as DEN is legal; it is sampled starting the cycle after DEN.
- Per entry, with the PLL answering DRDY on the cycle after DEN: 5 cycles (RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT).
- DRDY timeout: ERR asserts on the edge after the DRDY_TIMEOUT-th waiting cycle with no DRDY.
- A DRDY arriving on that same cycle wins over the timeout.
- LOCKED passes through a 2-flop synchronizer, so its latency into WAIT_LOCK is 2 cycles.
- A LOCKED that stays high from before reset release still counts as lock once synchronized.

## Structure
- Shared package pll_drp_pkg holds:
  - state enum;
  - DRP_ADDR_W=7 and DRP_DATA_W=16;
  - a function for the masked-merge expression.
- Sub-module pll_lock_sync is the 2-flop LOCKED synchronizer with a synchronous, active-low reset to 0.
- The table is external; benches provide a combinational lookup.

## Test plan
- Single entry: addr 0x08, mask 0x1000, data 0x0041, DO returns 0xFFFF.
  - Required: write DI=0x1041 and exactly two DEN pulses (DWE 0 then 1).
  - Required: PLL_RST falls after the write, then DONE=1 and BUSY=0.
- Full table NUM_ENTRIES=23, PLL model answering DRDY one cycle after DEN.
  - Required: 46 DEN pulses, ENTRY_IDX runs 0..22, and the write data at each address matches the merge function.
- DRDY withheld on entry 3 read, DRDY_TIMEOUT=64.
  - Required: ERR=1 at wait cycle 64, PLL_RST=0, BUSY=0, and no further DEN.
- LOCKED held low, LOCK_TIMEOUT=100.
  - Required: ERR=1 exactly 100 cycles after PLL_RST deasserts; DONE stays 0.
- START pulsed while BUSY.
  - Required: ignored; the sequence completes unchanged. START after FIN_ERR clears ERR and restarts from ENTRY_IDX=0.
- RSTN low during WR_WAIT.
  - Required: next edge shows all outputs at reset values. A stale DRDY afterwards causes no state change.
